// File: rtl/sprite_loader.sv
// sprite_loader: writer side of the sprite frame RAM.
// Packs a byte-serial R,G,B stream into 24-bit pixels and writes them row-major into one of
// BANKS sprite banks of DIM*DIM pixels. A registered read port serves the colour mapper.
// Optional feature: define SPRITE_LOADER_KEY_COUNT_EN to count key-colour pixels per load.
module sprite_loader #(
  parameter int unsigned      PIX_W     = 24,
  parameter int unsigned      DIM       = 32,
  parameter int unsigned      BANKS     = 4,
  parameter logic [PIX_W-1:0] KEY_COLOR = 24'hFF0000,
  localparam int unsigned     NPix      = DIM * DIM,
  localparam int unsigned     AddrW     = $clog2(NPix),
  localparam int unsigned     BankW     = $clog2(BANKS),
  localparam int unsigned     KcW       = AddrW + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [BankW-1:0]       bank_i,
  input  logic                   abort_i,
  input  logic                   byte_valid_i,
  input  logic [7:0]             byte_data_i,
  output logic                   byte_ready_o,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [BankW+AddrW-1:0] rd_addr_i,
  output logic [PIX_W-1:0]       rd_data_o,
  output logic [KcW-1:0]         key_count_o
);

  typedef enum logic [2:0] {StIdle, StGetR, StGetG, StGetB, StDone} state_e;

  state_e             state_q, state_d;
  logic [BankW-1:0]   bank_q, bank_d;
  logic [AddrW-1:0]   pix_addr_q, pix_addr_d;
  logic [7:0]         r_q, r_d;
  logic [7:0]         g_q, g_d;
  logic               we;
  logic               clr_kc;
  logic [PIX_W-1:0]   wdata;
  logic               key_hit;
  logic [PIX_W-1:0]   rd_data_q;
  logic [PIX_W-1:0]   mem_q [BANKS*NPix];

  assign wdata   = {r_q, g_q, byte_data_i};
  assign key_hit = we && (wdata == KEY_COLOR);

  // Control state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      bank_q     <= '0;
      pix_addr_q <= '0;
      r_q        <= '0;
      g_q        <= '0;
    end else begin
      state_q    <= state_d;
      bank_q     <= bank_d;
      pix_addr_q <= pix_addr_d;
      r_q        <= r_d;
      g_q        <= g_d;
    end
  end

  // Next-state, handshake and write-enable decode; abort wins over any byte transfer.
  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    pix_addr_d   = pix_addr_q;
    r_d          = r_q;
    g_d          = g_q;
    we           = 1'b0;
    clr_kc       = 1'b0;
    byte_ready_o = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy_o = 1'b0;
        if (start_i && !abort_i) begin
          bank_d     = bank_i;
          pix_addr_d = '0;
          clr_kc     = 1'b1;
          state_d    = StGetR;
        end
      end
      StGetR: begin
        // Ready drops during abort so the presented byte is visibly not consumed.
        byte_ready_o = !abort_i;
        if (abort_i) begin
          state_d = StIdle;
        end else if (byte_valid_i) begin
          r_d     = byte_data_i;
          state_d = StGetG;
        end
      end
      StGetG: begin
        byte_ready_o = !abort_i;
        if (abort_i) begin
          state_d = StIdle;
        end else if (byte_valid_i) begin
          g_d     = byte_data_i;
          state_d = StGetB;
        end
      end
      StGetB: begin
        byte_ready_o = !abort_i;
        if (abort_i) begin
          state_d = StIdle;
        end else if (byte_valid_i) begin
          we = 1'b1;
          if (pix_addr_q == AddrW'(NPix - 1)) begin
            state_d = StDone;
          end else begin
            pix_addr_d = pix_addr_q + AddrW'(1);
            state_d    = StGetR;
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel RAM write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[{bank_q, pix_addr_q}] <= wdata;
    end
  end

  // Registered read port; same-address write returns the old word.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

`ifdef SPRITE_LOADER_KEY_COUNT_EN
  logic [KcW-1:0] key_count_q;

  // Key-colour pixel counter, saturating at one full bank.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      key_count_q <= '0;
    end else if (clr_kc) begin
      key_count_q <= '0;
    end else if (key_hit && (key_count_q != KcW'(NPix))) begin
      key_count_q <= key_count_q + KcW'(1);
    end
  end

  assign key_count_o = key_count_q;
`else
  logic unused_key;
  assign unused_key  = key_hit ^ clr_kc;
  assign key_count_o = '0;
`endif

endmodule

// File: tb/tb_sprite_loader.sv
// Self-checking bench for sprite_loader: randomized streams checked every cycle against a
// byte-count/array reference model, plus literal expectations from the worked examples.
module tb_sprite_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  bank = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic [11:0] rd_addr = '0;
  logic [23:0] rd_data;
  logic [10:0] key_count;

  int checks = 0;
  int errors = 0;

`ifdef SPRITE_LOADER_KEY_COUNT_EN
  localparam bit KcEn = 1'b1;
`else
  localparam bit KcEn = 1'b0;
`endif

  sprite_loader dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .bank_i       (bank),
    .abort_i      (abort),
    .byte_valid_i (byte_valid),
    .byte_data_i  (byte_data),
    .byte_ready_o (byte_ready),
    .busy_o       (busy),
    .done_o       (done),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .key_count_o  (key_count)
  );

  always #5 clk = ~clk;

  // Reference model: a load is just a count of bytes taken (0..3072) into a known bank.
  logic [23:0] m_ram   [4096];
  bit          m_ram_v [4096];
  bit          m_load = 1'b0;
  bit          m_done = 1'b0;
  int          m_nb = 0;
  logic [1:0]  m_bank = '0;
  logic [7:0]  m_r = '0;
  logic [7:0]  m_g = '0;
  int          m_kc = 0;
  logic [23:0] m_rd = '0;
  bit          m_rd_v = 1'b1;
  int          done_pulses = 0;

  always @(posedge clk or posedge rst) begin
    int a;
    logic [23:0] px;
    if (rst) begin
      m_load = 1'b0;
      m_done = 1'b0;
      m_nb   = 0;
      m_kc   = 0;
      m_rd   = '0;
      m_rd_v = 1'b1;
    end else begin
      m_rd   = m_ram[rd_addr];
      m_rd_v = m_ram_v[rd_addr];
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_load) begin
        if (abort) begin
          m_load = 1'b0;
        end else if (byte_valid) begin
          if (m_nb % 3 == 0) m_r = byte_data;
          else if (m_nb % 3 == 1) m_g = byte_data;
          else begin
            a  = int'(m_bank) * 1024 + m_nb / 3;
            px = {m_r, m_g, byte_data};
            m_ram[a]   = px;
            m_ram_v[a] = 1'b1;
            if (px == 24'hFF0000 && m_kc < 1024) m_kc++;
          end
          m_nb++;
          if (m_nb == 3072) begin
            m_load = 1'b0;
            m_done = 1'b1;
          end
        end
      end else if (start && !abort) begin
        m_load = 1'b1;
        m_bank = bank;
        m_nb   = 0;
        m_kc   = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    #2;
    chk("byte_ready", 32'(byte_ready), 32'(m_load && !abort));
    chk("busy", 32'(busy), 32'(m_load || m_done));
    chk("done", 32'(done), 32'(m_done));
    chk("key_count", 32'(key_count), KcEn ? 32'(m_kc) : 32'd0);
    if (m_rd_v) chk("rd_data", 32'(rd_data), 32'(m_rd));
    if (done) done_pulses++;
  end

  // Byte for stream position nb: 0 = ramp pattern, 2 = sparse key pixels, else random.
  function automatic logic [7:0] gen(input int mode, input int nb);
    int p;
    int k;
    logic [7:0] pi;
    p  = nb / 3;
    k  = nb % 3;
    pi = 8'(p);
    if (mode == 0) return (k == 0) ? pi : (k == 1) ? 8'hA5 : ~pi;
    if (mode == 2) begin
      if (p % 27 == 0 && p < 999) return (k == 0) ? 8'hFF : 8'h00;
      return (k == 0) ? 8'h00 : 8'($urandom);
    end
    return 8'($urandom);
  endfunction

  // One load. vmode: 0 valid high, 1 valid in odd cycles, 2 random. stop_act 1 aborts and
  // 2 resets when the model has taken stop_nb bytes. lat is the cycle index of done.
  task automatic load(input logic [1:0] b, input int mode, input int vmode, input int stop_nb,
                      input int stop_act, input bit inj, input bit rw, output int lat);
    int c;
    lat = -1;
    @(negedge clk);
    start = 1'b1;
    bank  = b;
    abort = 1'b0;
    byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    while (1) begin
      if (c > 20000) begin
        checks++;
        errors++;
        $display("FAIL load_timeout: no done after %0d cycles, required within 20000", c);
        break;
      end
      byte_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? 1'(c & 1) : 1'($urandom_range(0, 1));
      byte_data  = gen(mode, m_nb);
      rd_addr    = rw ? {b, 10'(m_nb / 3)} : 12'($urandom);
      start      = inj && ($urandom_range(0, 49) == 0);
      bank       = start ? 2'd3 : b;
      if (stop_nb >= 0 && m_load && m_nb == stop_nb) begin
        if (stop_act == 1) begin
          abort = 1'b1;
          byte_valid = 1'b1;
          @(negedge clk);
          abort = 1'b0;
          byte_valid = 1'b0;
          #3;
          chk("abort_idle_busy", 32'(busy), 32'd0);
          chk("abort_idle_ready", 32'(byte_ready), 32'd0);
        end else begin
          rst = 1'b1;
          #3;
          chk("rst_mid_busy", 32'(busy), 32'd0);
          chk("rst_mid_ready", 32'(byte_ready), 32'd0);
          chk("rst_mid_done", 32'(done), 32'd0);
          @(negedge clk);
          rst = 1'b0;
        end
        break;
      end
      #3;
      if (done) begin
        lat = c;
        break;
      end
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    start = 1'b0;
    bank = b;
    byte_valid = 1'b0;
    abort = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rd_addr = 12'($urandom);
    end
  endtask

  task automatic sweep(input logic [1:0] b);
    for (int i = 0; i < 1024; i++) begin
      @(negedge clk);
      rd_addr = {b, 10'(i)};
    end
  endtask

  task automatic rd_lit(input logic [11:0] a, input logic [23:0] exp, input string name);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    #3;
    chk(name, 32'(rd_data), 32'(exp));
  endtask

  initial begin
    int lat;
    int dp;
    repeat (3) @(negedge clk);
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_ready", 32'(byte_ready), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_rd_data", 32'(rd_data), 32'd0);
    chk("reset_key_count", 32'(key_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full ramp load of bank 2, valid always high.
    dp = done_pulses;
    load(2'd2, 0, 0, -1, 0, 1'b0, 1'b0, lat);
    chk("latency_full", 32'(lat), 32'd3073);
    idle(3);
    chk("done_once_full", 32'(done_pulses - dp), 32'd1);
    rd_lit({2'd2, 10'd7}, 24'h07A5F8, "rd_bank2_px7");

    // Same load with valid every other cycle.
    dp = done_pulses;
    load(2'd2, 0, 1, -1, 0, 1'b0, 1'b0, lat);
    chk("latency_toggle", 32'(lat), 32'd6144);
    idle(3);
    chk("done_once_toggle", 32'(done_pulses - dp), 32'd1);
    sweep(2'd2);
    rd_lit({2'd2, 10'd200}, 24'hC8A537, "rd_bank2_px200");

    // Random bank 3, then bank 1 with stray start requests for bank 3.
    load(2'd3, 1, 2, -1, 0, 1'b0, 1'b0, lat);
    dp = done_pulses;
    load(2'd1, 1, 2, -1, 0, 1'b1, 1'b0, lat);
    idle(3);
    chk("done_once_inject", 32'(done_pulses - dp), 32'd1);
    sweep(2'd3);
    sweep(2'd1);

    // Abort in the B phase of pixel 100.
    dp = done_pulses;
    load(2'd0, 0, 2, 302, 1, 1'b0, 1'b0, lat);
    idle(4);
    chk("abort_no_done", 32'(done_pulses - dp), 32'd0);
    rd_lit({2'd0, 10'd99}, 24'h63A59C, "abort_px99_written");
    rd_lit({2'd0, 10'd0}, 24'h00A5FF, "abort_px0_written");
    @(negedge clk);
    rd_addr = {2'd0, 10'd100};
    @(negedge clk);
    #3;
    chk("abort_px100_unwritten", 32'(rd_data == 24'h64A59B), 32'd0);

    // Reset in the G phase of pixel 5, then a fresh random reload.
    load(2'd1, 0, 2, 16, 2, 1'b0, 1'b0, lat);
    rd_lit({2'd1, 10'd4}, 24'h04A5FB, "rst_px4_kept");
    load(2'd1, 1, 0, -1, 0, 1'b0, 1'b0, lat);
    chk("latency_after_rst", 32'(lat), 32'd3073);
    sweep(2'd1);

    // Sparse key-colour pixels into bank 0.
    load(2'd0, 2, 2, -1, 0, 1'b0, 1'b0, lat);
    chk("key_count_after_done", 32'(key_count), KcEn ? 32'd37 : 32'd0);
    idle(2);
    chk("key_count_holds", 32'(key_count), KcEn ? 32'd37 : 32'd0);
    sweep(2'd0);

    // Read the address being written on every cycle of a load.
    load(2'd3, 0, 2, -1, 0, 1'b0, 1'b1, lat);
    sweep(2'd3);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
